// File: rtl/mhp_rx_parser.sv
// -----------------------------------------------------------------------------
// mhp_rx_parser
// Receive-side decoder for MHP frames read out of the Ethernet RX payload FIFO.
// Pops bytes with a two-phase rreq/rdata handshake and parses the 6-byte
// header (dst, src, d_type, length). It streams the payload and verifies the
// trailing 16-bit additive checksum. Frames whose destination is neither this
// node nor broadcast are dropped. One status strobe is reported per accepted
// frame.
//
// Frame layout (big-endian):
//   dst[15:8] dst[7:0] src[15:8] src[7:0] d_type len  payload[len]  cs_hi cs_lo
//   cs = (sum of all bytes before the checksum) mod 2^16.
//   Bytes after the checksum are padding and are discarded.
//   A frame ends when GAP_CYCLES consecutive idle cycles are seen.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_rdata, i_rready FIFO read data (valid the cycle after o_rreq), FIFO non-empty
//   o_rreq            one-cycle FIFO pop request, never on consecutive cycles
//   o_dst, o_src      captured addresses, held until the next frame's header
//   o_dir, o_type     d_type[7], d_type[6:0]
//   o_len             captured length byte
//   o_pdata, o_pvalid payload byte and 1-cycle strobe (no backpressure)
//   o_plast           with o_pvalid on the final payload byte
//   o_frame_done      1-cycle end-of-frame status strobe
//   o_frame_ok, o_err_cs, o_err_len, o_err_trunc
//                     mutually exclusive status flags, qualified by o_frame_done
//   o_drop            1-cycle pulse when the address filter discards a frame
//   o_busy            high whenever the parser is not idle
// -----------------------------------------------------------------------------
module mhp_rx_parser #(
    parameter logic [15:0] MY_ADDR     = 16'h0000,
    parameter int unsigned MAX_PAYLOAD = 64,
    parameter int unsigned GAP_CYCLES  = 63
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rdata,
    input  logic        i_rready,
    output logic        o_rreq,
    output logic [15:0] o_dst,
    output logic [15:0] o_src,
    output logic        o_dir,
    output logic [6:0]  o_type,
    output logic [7:0]  o_len,
    output logic [7:0]  o_pdata,
    output logic        o_pvalid,
    output logic        o_plast,
    output logic        o_frame_done,
    output logic        o_frame_ok,
    output logic        o_err_cs,
    output logic        o_err_len,
    output logic        o_err_trunc,
    output logic        o_drop,
    output logic        o_busy
);

    localparam logic [7:0]  MAX_LEN_C  = 8'(MAX_PAYLOAD);
    // The gap counter starts at 0 after a capture, so the final idle cycle
    // of the gap is seen while the counter holds GAP_CYCLES-1.
    localparam logic [7:0]  GAP_LAST_C = 8'(GAP_CYCLES - 1);
    localparam logic [15:0] BCAST_C    = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CKSUM   = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    // 16-bit wrap-around accumulation of one received byte.
    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [7:0] b);
        csum_add = acc + {8'h00, b};
    endfunction

    state_t      state_r;
    logic        rreq_r;       // pop request currently on o_rreq
    logic        cap_r;        // i_rdata holds a popped byte this cycle
    logic [7:0]  gap_cnt_r;
    logic [7:0]  idx_r;        // byte index within the current section
    logic [15:0] sum_r;
    logic [7:0]  dst_hi_r;
    logic [7:0]  src_hi_r;
    logic [7:0]  cs_hi_r;
    logic        pend_len_r;   // length error waiting for the gap to report

    logic [15:0] dst_r;
    logic [15:0] src_r;
    logic        dir_r;
    logic [6:0]  type_r;
    logic [7:0]  len_r;
    logic [7:0]  pdata_r;
    logic        pvalid_r;
    logic        plast_r;
    logic        done_r;
    logic        ok_r;
    logic        err_cs_r;
    logic        err_len_r;
    logic        err_trunc_r;
    logic        drop_r;
    logic        busy_r;

    logic        idle_tick_s;
    logic        gap_hit_s;
    logic        can_req_s;
    logic        dst_ok_s;
    logic        len_bad_s;

    // Classify the current cycle for the fetch engine and the header decision.
    always_comb begin
        idle_tick_s = 1'b0;
        gap_hit_s   = 1'b0;
        can_req_s   = 1'b0;
        dst_ok_s    = 1'b0;
        len_bad_s   = 1'b0;
        // A request may go out on any cycle that is not itself a request cycle.
        if (!rreq_r && i_rready) begin
            can_req_s = 1'b1;
        end else begin
            can_req_s = 1'b0;
        end
        // Only cycles with no request and no capture count toward the gap.
        if ((state_r != ST_IDLE) && !rreq_r && !cap_r && !i_rready) begin
            idle_tick_s = 1'b1;
        end else begin
            idle_tick_s = 1'b0;
        end
        if (idle_tick_s && (gap_cnt_r == GAP_LAST_C)) begin
            gap_hit_s = 1'b1;
        end else begin
            gap_hit_s = 1'b0;
        end
        if ((dst_r == MY_ADDR) || (dst_r == BCAST_C)) begin
            dst_ok_s = 1'b1;
        end else begin
            dst_ok_s = 1'b0;
        end
        if ((i_rdata == 8'd0) || (i_rdata > MAX_LEN_C)) begin
            len_bad_s = 1'b1;
        end else begin
            len_bad_s = 1'b0;
        end
    end

    // Parser FSM, byte fetch engine and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            rreq_r      <= 1'b0;
            cap_r       <= 1'b0;
            gap_cnt_r   <= 8'd0;
            idx_r       <= 8'd0;
            sum_r       <= 16'd0;
            dst_hi_r    <= 8'd0;
            src_hi_r    <= 8'd0;
            cs_hi_r     <= 8'd0;
            pend_len_r  <= 1'b0;
            dst_r       <= 16'd0;
            src_r       <= 16'd0;
            dir_r       <= 1'b0;
            type_r      <= 7'd0;
            len_r       <= 8'd0;
            pdata_r     <= 8'd0;
            pvalid_r    <= 1'b0;
            plast_r     <= 1'b0;
            done_r      <= 1'b0;
            ok_r        <= 1'b0;
            err_cs_r    <= 1'b0;
            err_len_r   <= 1'b0;
            err_trunc_r <= 1'b0;
            drop_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            pvalid_r    <= 1'b0;
            plast_r     <= 1'b0;
            done_r      <= 1'b0;
            ok_r        <= 1'b0;
            err_cs_r    <= 1'b0;
            err_len_r   <= 1'b0;
            err_trunc_r <= 1'b0;
            drop_r      <= 1'b0;
            rreq_r      <= 1'b0;
            cap_r       <= rreq_r;

            if (state_r == ST_IDLE) begin
                sum_r      <= 16'd0;
                idx_r      <= 8'd0;
                gap_cnt_r  <= 8'd0;
                pend_len_r <= 1'b0;
                if (i_rready) begin
                    rreq_r  <= 1'b1;
                    state_r <= ST_HDR;
                    busy_r  <= 1'b1;
                end else begin
                    state_r <= ST_IDLE;
                end
            end else begin
                if (can_req_s) begin
                    rreq_r <= 1'b1;
                end else begin
                    rreq_r <= 1'b0;
                end

                if (cap_r) begin
                    gap_cnt_r <= 8'd0;
                end else if (idle_tick_s) begin
                    gap_cnt_r <= gap_cnt_r + 8'd1;
                end else begin
                    gap_cnt_r <= gap_cnt_r;
                end

                if (gap_hit_s) begin
                    // Gap ends the frame: truncation while still parsing,
                    // deferred length error when draining a bad frame.
                    case (state_r)
                        ST_HDR, ST_PAYLOAD, ST_CKSUM: begin
                            done_r      <= 1'b1;
                            err_trunc_r <= 1'b1;
                        end
                        ST_DRAIN: begin
                            if (pend_len_r) begin
                                done_r    <= 1'b1;
                                err_len_r <= 1'b1;
                            end else begin
                                done_r <= 1'b0;
                            end
                        end
                        default: begin
                            done_r <= 1'b0;
                        end
                    endcase
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    gap_cnt_r <= 8'd0;
                end else if (cap_r) begin
                    case (state_r)
                        ST_HDR: begin
                            sum_r <= csum_add(sum_r, i_rdata);
                            idx_r <= idx_r + 8'd1;
                            case (idx_r)
                                8'd0: dst_hi_r <= i_rdata;
                                8'd1: dst_r    <= {dst_hi_r, i_rdata};
                                8'd2: src_hi_r <= i_rdata;
                                8'd3: src_r    <= {src_hi_r, i_rdata};
                                8'd4: begin
                                    dir_r  <= i_rdata[7];
                                    type_r <= i_rdata[6:0];
                                end
                                8'd5: begin
                                    len_r <= i_rdata;
                                    idx_r <= 8'd0;
                                    if (!dst_ok_s) begin
                                        drop_r  <= 1'b1;
                                        state_r <= ST_DRAIN;
                                    end else if (len_bad_s) begin
                                        pend_len_r <= 1'b1;
                                        state_r    <= ST_DRAIN;
                                    end else begin
                                        state_r <= ST_PAYLOAD;
                                    end
                                end
                                default: begin
                                    state_r <= ST_DRAIN;
                                end
                            endcase
                        end
                        ST_PAYLOAD: begin
                            sum_r    <= csum_add(sum_r, i_rdata);
                            pdata_r  <= i_rdata;
                            pvalid_r <= 1'b1;
                            if (idx_r == (len_r - 8'd1)) begin
                                plast_r <= 1'b1;
                                idx_r   <= 8'd0;
                                state_r <= ST_CKSUM;
                            end else begin
                                idx_r <= idx_r + 8'd1;
                            end
                        end
                        ST_CKSUM: begin
                            // Checksum bytes are compared, never accumulated.
                            if (idx_r == 8'd0) begin
                                cs_hi_r <= i_rdata;
                                idx_r   <= 8'd1;
                            end else begin
                                done_r  <= 1'b1;
                                idx_r   <= 8'd0;
                                state_r <= ST_DRAIN;
                                if ({cs_hi_r, i_rdata} == sum_r) begin
                                    ok_r <= 1'b1;
                                end else begin
                                    err_cs_r <= 1'b1;
                                end
                            end
                        end
                        ST_DRAIN: begin
                            state_r <= ST_DRAIN;
                        end
                        default: begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    endcase
                end else begin
                    state_r <= state_r;
                end
            end
        end
    end

    assign o_rreq       = rreq_r;
    assign o_dst        = dst_r;
    assign o_src        = src_r;
    assign o_dir        = dir_r;
    assign o_type       = type_r;
    assign o_len        = len_r;
    assign o_pdata      = pdata_r;
    assign o_pvalid     = pvalid_r;
    assign o_plast      = plast_r;
    assign o_frame_done = done_r;
    assign o_frame_ok   = ok_r;
    assign o_err_cs     = err_cs_r;
    assign o_err_len    = err_len_r;
    assign o_err_trunc  = err_trunc_r;
    assign o_drop       = drop_r;
    assign o_busy       = busy_r;

endmodule

// File: tb/tb_mhp_rx_parser.sv
// Scoreboard bench for mhp_rx_parser: directed frames are fed through a FIFO
// model, expected events are queued at stimulus time and a monitor pops and
// compares them whenever the parser strobes an output.
module tb_mhp_rx_parser;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_rdata = 8'd0;
    logic        i_rready = 1'b0;
    logic        o_rreq;
    logic [15:0] o_dst;
    logic [15:0] o_src;
    logic        o_dir;
    logic [6:0]  o_type;
    logic [7:0]  o_len;
    logic [7:0]  o_pdata;
    logic        o_pvalid;
    logic        o_plast;
    logic        o_frame_done;
    logic        o_frame_ok;
    logic        o_err_cs;
    logic        o_err_len;
    logic        o_err_trunc;
    logic        o_drop;
    logic        o_busy;

    always #5 i_clk = ~i_clk;

    mhp_rx_parser #(
        .MY_ADDR(16'h0000),
        .MAX_PAYLOAD(64),
        .GAP_CYCLES(63)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_rdata(i_rdata),
        .i_rready(i_rready),
        .o_rreq(o_rreq),
        .o_dst(o_dst),
        .o_src(o_src),
        .o_dir(o_dir),
        .o_type(o_type),
        .o_len(o_len),
        .o_pdata(o_pdata),
        .o_pvalid(o_pvalid),
        .o_plast(o_plast),
        .o_frame_done(o_frame_done),
        .o_frame_ok(o_frame_ok),
        .o_err_cs(o_err_cs),
        .o_err_len(o_err_len),
        .o_err_trunc(o_err_trunc),
        .o_drop(o_drop),
        .o_busy(o_busy)
    );

    localparam int K_PAY  = 0;
    localparam int K_DONE = 1;
    localparam int K_DROP = 2;
    // Flag order: {ok, err_cs, err_len, err_trunc}
    localparam logic [3:0] FL_OK = 4'b1000;
    localparam logic [3:0] FL_CS = 4'b0100;
    localparam logic [3:0] FL_LN = 4'b0010;
    localparam logic [3:0] FL_TR = 4'b0001;

    typedef struct {
        int          kind;
        logic [7:0]  d;
        logic        last;
        logic [3:0]  fl;
        logic        hdr;
        logic [47:0] hv;   // {dst, src, dir, type, len}
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] fifo[$];
    logic [7:0] fr[$];
    int         pop_cnt = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic logic [47:0] hv_of(input logic [15:0] d, input logic [15:0] s,
                                          input logic [7:0] dt, input logic [7:0] l);
        hv_of = {d, s, dt, l};
    endfunction

    task automatic check(input string nm, input logic [65:0] got, input logic [65:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    task automatic exp_pay(input logic [7:0] d, input logic last);
        ev_t e;
        e = '{kind: K_PAY, d: d, last: last, fl: 4'd0, hdr: 1'b0, hv: 48'd0};
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input logic [3:0] fl, input logic [47:0] hv);
        ev_t e;
        e = '{kind: K_DONE, d: 8'd0, last: 1'b0, fl: fl, hdr: 1'b1, hv: hv};
        exp_q.push_back(e);
    endtask

    task automatic exp_drop(input logic [15:0] dst);
        ev_t e;
        e = '{kind: K_DROP, d: 8'd0, last: 1'b0, fl: 4'd0, hdr: 1'b0, hv: {dst, 32'd0}};
        exp_q.push_back(e);
    endtask

    // Pop the next expected event; reports a failure if none or wrong kind.
    task automatic take(input int kind, input string nm, output ev_t e, output bit ok);
        ok = 1'b0;
        e = '{kind: -1, d: 8'd0, last: 1'b0, fl: 4'd0, hdr: 1'b0, hv: 48'd0};
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_unexpected: got strobe, required none", nm);
        end else begin
            e = exp_q.pop_front();
            check({nm, "_kind"}, 66'(e.kind), 66'(kind));
            ok = (e.kind == kind);
        end
    endtask

    // FIFO model: a pop request makes the front byte appear on i_rdata.
    initial begin : fifo_model
        forever begin
            @(negedge i_clk);
            if (o_rreq) begin
                pop_cnt++;
                if (fifo.size() > 0) begin
                    i_rdata = fifo.pop_front();
                end else begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL fifo_underflow: got pop with %0d bytes, required >0", fifo.size());
                end
            end
            i_rready = (fifo.size() != 0);
        end
    end

    // Monitor: protocol invariants plus scoreboard comparisons.
    initial begin : monitor
        logic prev_rreq;
        ev_t  e;
        bit   ok;
        prev_rreq = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_rreq) check("rreq_consecutive", 66'(prev_rreq), 66'd0);
            prev_rreq = o_rreq;
            if (!o_frame_done)
                check("flags_unqualified", 66'({o_frame_ok, o_err_cs, o_err_len, o_err_trunc}), 66'd0);
            if (o_plast) check("plast_without_pvalid", 66'(o_pvalid), 66'd1);
            if (o_pvalid) begin
                take(K_PAY, "payload", e, ok);
                if (ok) check("payload_byte", 66'({o_pdata, o_plast}), 66'({e.d, e.last}));
            end
            if (o_frame_done) begin
                take(K_DONE, "done", e, ok);
                if (ok) begin
                    check("done_flags", 66'({o_frame_ok, o_err_cs, o_err_len, o_err_trunc}), 66'(e.fl));
                    if (e.hdr) check("done_header", 66'({o_dst, o_src, o_dir, o_type, o_len}), 66'(e.hv));
                end
            end
            if (o_drop) begin
                take(K_DROP, "drop", e, ok);
                if (ok) check("drop_dst", 66'(o_dst), 66'(e.hv[47:32]));
            end
        end
    end

    task automatic feed();
        @(posedge i_clk);
        #1;
        pop_cnt = 0;
        foreach (fr[i]) fifo.push_back(fr[i]);
    endtask

    // Wait for the parser to return to idle, then check leftovers and pops.
    task automatic finish(input string nm, input int pops);
        bit done;
        done = 1'b0;
        repeat (4) @(negedge i_clk);
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge i_clk);
            if (!o_busy && fifo.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got busy after 2000 cycles, required idle", nm);
        end
        check({nm, "_events_left"}, 66'(exp_q.size()), 66'd0);
        check({nm, "_pops"}, 66'(pop_cnt), 66'(pops));
        check({nm, "_busy"}, 66'(o_busy), 66'd0);
        exp_q.delete();
    endtask

    function automatic logic [65:0] all_outs();
        all_outs = {o_rreq, o_dst, o_src, o_dir, o_type, o_len, o_pdata, o_pvalid, o_plast,
                    o_frame_done, o_frame_ok, o_err_cs, o_err_len, o_err_trunc, o_drop, o_busy};
    endfunction

    initial begin : stimulus
        bit found;
        // Reset state
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        check("reset_outputs", all_outs(), 66'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        check("post_reset_outputs", all_outs(), 66'd0);

        // Good broadcast frame
        exp_pay(8'hAA, 1'b0);
        exp_pay(8'hBB, 1'b1);
        exp_done(FL_OK, hv_of(16'hFFFF, 16'h0000, 8'h83, 8'h02));
        fr = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h83, 8'h02, 8'hAA, 8'hBB, 8'h03, 8'hE8};
        feed();
        finish("good", 10);

        // Bad checksum
        exp_pay(8'hAA, 1'b0);
        exp_pay(8'hBB, 1'b1);
        exp_done(FL_CS, hv_of(16'hFFFF, 16'h0000, 8'h83, 8'h02));
        fr = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h83, 8'h02, 8'hAA, 8'hBB, 8'h03, 8'hE9};
        feed();
        finish("bad_cs", 10);

        // Address filter drop
        exp_drop(16'h1234);
        fr = {8'h12, 8'h34, 8'h00, 8'h00, 8'h83, 8'h02, 8'hAA, 8'hBB, 8'h03, 8'hE8};
        feed();
        finish("drop", 10);

        // Zero length
        exp_done(FL_LN, hv_of(16'hFFFF, 16'h0000, 8'h83, 8'h00));
        fr = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h83, 8'h00, 8'h00, 8'h00};
        feed();
        finish("len_zero", 8);

        // Length one above MAX_PAYLOAD
        exp_done(FL_LN, hv_of(16'hFFFF, 16'h0000, 8'h83, 8'h41));
        fr = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h83, 8'h41, 8'h01, 8'h02, 8'h03};
        feed();
        finish("len_big", 9);

        // Truncated payload
        exp_pay(8'h11, 1'b0);
        exp_pay(8'h22, 1'b0);
        exp_done(FL_TR, hv_of(16'hFFFF, 16'h0000, 8'h83, 8'h04));
        fr = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h83, 8'h04, 8'h11, 8'h22};
        feed();
        finish("trunc", 8);

        // Good frame plus 36 padding bytes, i_rready high throughout
        exp_pay(8'hAA, 1'b0);
        exp_pay(8'hBB, 1'b1);
        exp_done(FL_OK, hv_of(16'hFFFF, 16'h0000, 8'h83, 8'h02));
        fr = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h83, 8'h02, 8'hAA, 8'hBB, 8'h03, 8'hE8};
        for (int i = 0; i < 36; i++) fr.push_back(8'h00);
        feed();
        finish("padding", 46);

        // Reset during payload
        exp_pay(8'h11, 1'b0);
        fr = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h83, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        feed();
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge i_clk);
            if (o_pvalid) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL rst_mid_timeout: got no payload strobe, required one");
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rst_mid_outputs", all_outs(), 66'd0);
        @(posedge i_clk);
        #1;
        fifo.delete();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (100) @(negedge i_clk);
        check("rst_mid_events_left", 66'(exp_q.size()), 66'd0);
        check("rst_mid_busy", 66'(o_busy), 66'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mhp_rx_parser.md
Name: mhp_rx_parser

Overview:
- Receive-side decoder for MHP frames arriving in the Ethernet RX payload FIFO.
- Pulls bytes using the same rready/rreq handshake the MHP handler uses, and parses the header: dst addr, src addr, d_type, length.
- Streams the payload, verifies the 16-bit checksum, applies an address filter, and reports a per-frame status.
- Sits between the Ethernet RX FIFO and the command processor; it is the decoding counterpart of the MHP frame builder.

Parameters:
- MY_ADDR, 16'h0000, local node address; frames with dst == MY_ADDR or dst == 16'hFFFF are accepted.
- MAX_PAYLOAD, 64, largest legal length byte; 1..255.
- GAP_CYCLES, 63, consecutive idle cycles (i_rready low) that terminate a frame; 2..255.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_rdata  in  8  FIFO read data; valid the cycle after o_rreq.
- i_rready  in  1  FIFO non-empty.
- o_rreq  out  1  one-cycle FIFO pop request.
- o_dst  out  16  captured destination address.
- o_src  out  16  captured source address.
- o_dir  out  1  d_type[7].
- o_type  out  7  d_type[6:0].
- o_len  out  8  captured length byte.
- o_pdata  out  8  payload byte.
- o_pvalid  out  1  payload byte strobe, 1 cycle; no backpressure.
- o_plast  out  1  with o_pvalid on the final payload byte.
- o_frame_done  out  1  1-cycle end-of-frame status strobe.
- o_frame_ok  out  1  qualified by o_frame_done.
- o_err_cs  out  1  qualified by o_frame_done; checksum mismatch.
- o_err_len  out  1  qualified by o_frame_done; length 0 or > MAX_PAYLOAD.
- o_err_trunc  out  1  qualified by o_frame_done; gap before checksum complete.
- o_drop  out  1  1-cycle pulse; frame discarded by the address filter.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Frame layout, big-endian:
  - bytes 0-1 dst; bytes 2-3 src; byte 4 d_type; byte 5 length N;
  - N payload bytes; 2 checksum bytes.
  - Checksum = sum mod 2^16 of bytes 0..5+N.
  - Any bytes after the checksum are Ethernet padding and are discarded silently.
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame abandons the frame; no status strobe is produced.
- Byte fetch: two-phase.
  - REQ phase: when i_rready=1, assert o_rreq for exactly one cycle.
  - CAP phase, next cycle: sample i_rdata and add it to the 16-bit running sum.
  - o_rreq is never high in two consecutive cycles. Maximum throughput is 1 byte per 2 cycles.
- Gap counter: increments in REQ phase while i_rready=0; clears on each captured byte. Reaching GAP_CYCLES is a gap event.
- States:
  - IDLE: sum=0, byte index=0. On i_rready go to HDR and issue the first request.
  - HDR: capture 6 bytes into o_dst/o_src/o_dir/o_type/o_len. o_dst, o_src, o_dir, o_type and o_len update when their last byte is captured and hold until the next frame's header.
    - After byte 5, dst not accepted -> pulse o_drop, go to DRAIN. No o_frame_done.
    - Else N==0 or N>MAX_PAYLOAD -> go to DRAIN; at the gap, o_frame_done with o_err_len=1.
    - Else go to PAYLOAD.
  - PAYLOAD: each captured byte is presented on o_pdata with o_pvalid=1 in the cycle after CAP (1-cycle latency). o_plast is high on byte N. Then go to CKSUM.
  - CKSUM: capture 2 bytes, MSB first. The checksum bytes are not added to the sum.
    - After the LSB: o_frame_done=1 the next cycle; o_frame_ok=1 iff received checksum == sum, otherwise o_err_cs=1.
    - Then go to DRAIN.
  - DRAIN: pop and discard bytes until a gap event, then go to IDLE.
- Gap event in HDR, PAYLOAD or CKSUM: o_frame_done with o_err_trunc=1, then go to IDLE.
  - Payload bytes already strobed are not retracted.
  - o_plast is not generated for a truncated frame.
- Status flags are exclusive: exactly one of ok/err_cs/err_len/err_trunc is high with o_frame_done. All flags are 0 when o_frame_done=0.
- Sum arithmetic: 16-bit wrap-around, carries discarded.
- Back-to-back frames must be separated by a gap of at least GAP_CYCLES. Bytes of a following frame arriving before the gap are drained as padding.

Test Plan:
- Good broadcast frame, MY_ADDR=0: feed FF FF 00 00 83 02 AA BB 03 E8, then idle 63 cycles.
  - o_dst=FFFF, o_src=0000, o_dir=1, o_type=03, o_len=02.
  - o_pdata AA then BB, o_plast with BB.
  - o_frame_done with o_frame_ok=1; return to IDLE after the gap.
- Same frame with checksum 03 E9 -> o_err_cs=1, o_frame_ok=0; payload AA, BB still strobed.
- dst=1234, MY_ADDR=0 -> o_drop pulse after byte 5; no o_pvalid; no o_frame_done; all 10 bytes popped.
- Length byte 00, then length 41 with MAX_PAYLOAD=64 (0x41=65) -> after the gap, o_frame_done with o_err_len=1, no o_pvalid.
- Truncation: FF FF 00 00 83 04 11 22, then idle -> two o_pvalid strobes; after 63 idle cycles, o_frame_done with o_err_trunc=1.
- Padding and handshake:
  - Good frame followed by 36 bytes of 00 -> o_frame_ok=1, all 46 bytes popped.
  - i_rready held high throughout -> o_rreq alternates 1,0.
  - Assert i_rst during PAYLOAD -> all outputs 0 next cycle, no o_frame_done.
